// File: rtl/edge_evt_pkg.sv
// Shared types for the edge-event arbiter: event record, output-register states
// and the channel-count ceiling.
package edge_evt_pkg;

    localparam int MAX_CH   = 16;
    localparam int MAX_CH_W = $clog2(MAX_CH);

    typedef struct packed {
        logic [MAX_CH_W-1:0] ch;
        logic                pol;
    } evt_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event port: the arbiter is the master, the consumer is the slave.
interface edge_event_arbiter_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_pol;

    modport master (output evt_valid, output evt_ch, output evt_pol, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, input evt_pol, output evt_ready);
endinterface

// File: rtl/edge_sync_det.sv
// One channel: multi-flop synchronizer, previous-value register and
// enable-gated rising/falling edge strobes.
module edge_sync_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic pos_en,
    input  logic neg_en,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s & ~prev_q & pos_en;
    assign fall = ~s & prev_q & neg_en;
endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-event scheduler: per-channel edge detectors feed one-deep pending slots,
// which a round-robin arbiter drains onto a single valid/ready event port.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       din,
    input  logic [N_CH-1:0]       pos_en,
    input  logic [N_CH-1:0]       neg_en,
    input  logic                  ovf_clr,
    output logic [N_CH-1:0]       ovf,
    edge_event_arbiter_if.master  evt
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0] rise, fall;
    logic [N_CH-1:0] pend_v_q, pend_v_d;
    logic [N_CH-1:0] pend_pol_q, pend_pol_d;
    logic [N_CH-1:0] ovf_q, ovf_d, ovf_set;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic            out_pol_q, out_pol_d;
    out_state_e      state_q, state_d;

    logic [CH_W-1:0] grant_ch, idx;
    logic            grant_found, take, do_grant, granted_c;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        edge_sync_det #(.SYNC_STAGES(SYNC_STAGES)) u_det (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (din[g]),
            .pos_en (pos_en[g]),
            .neg_en (neg_en[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
    end

    // Rotating priority: the channel just after the last grant is looked at first.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        idx         = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = CH_W'((int'(rr_ptr_q) + i) % N_CH);
            if (!grant_found && pend_v_q[idx]) begin
                grant_found = 1'b1;
                grant_ch    = idx;
            end
        end
    end

    assign take     = (state_q == EMPTY) || evt.evt_ready;
    assign do_grant = take && grant_found;

    // A slot being drained this cycle can accept a new edge without overflowing.
    always_comb begin
        pend_v_d   = pend_v_q;
        pend_pol_d = pend_pol_q;
        ovf_set    = '0;
        granted_c  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            granted_c = do_grant && (grant_ch == CH_W'(c));
            if (granted_c) pend_v_d[c] = 1'b0;
            if (rise[c] || fall[c]) begin
                if (!pend_v_q[c] || granted_c) begin
                    pend_v_d[c]   = 1'b1;
                    pend_pol_d[c] = rise[c];
                end else begin
                    ovf_set[c] = 1'b1;
                end
            end
        end
        ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
    end

    always_comb begin
        state_d   = state_q;
        out_ch_d  = out_ch_q;
        out_pol_d = out_pol_q;
        rr_ptr_d  = rr_ptr_q;
        if (take) begin
            if (grant_found) begin
                state_d   = FULL;
                out_ch_d  = grant_ch;
                out_pol_d = pend_pol_q[grant_ch];
                rr_ptr_d  = grant_ch;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q   <= '0;
            pend_pol_q <= '0;
            ovf_q      <= '0;
            rr_ptr_q   <= CH_W'(N_CH - 1);
            out_ch_q   <= '0;
            out_pol_q  <= 1'b0;
            state_q    <= EMPTY;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_pol_q <= pend_pol_d;
            ovf_q      <= ovf_d;
            rr_ptr_q   <= rr_ptr_d;
            out_ch_q   <= out_ch_d;
            out_pol_q  <= out_pol_d;
            state_q    <= state_d;
        end
    end

    assign evt.evt_valid = (state_q == FULL);
    assign evt.evt_ch    = out_ch_q;
    assign evt.evt_pol   = out_pol_q;
    assign ovf           = ovf_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: expected events are queued as pins are
// driven and checked (channel, polarity, arrival cycle) when the consumer accepts them.
module tb_edge_event_arbiter;
    import edge_evt_pkg::*;

    typedef struct {
        evt_t evt;
        int   cyc;
    } sbEntry_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] din, posEn, negEn, ovf;
    logic       ovfClr;
    int         cyc;
    int         checkCount;
    int         passCount;
    sbEntry_t   sb[$];

    edge_event_arbiter_if #(.N_CH(4)) evtIf ();

    edge_event_arbiter #(.N_CH(4), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .pos_en  (posEn),
        .neg_en  (negEn),
        .ovf_clr (ovfClr),
        .ovf     (ovf),
        .evt     (evtIf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] newDin, input logic [3:0] newPos, input logic [3:0] newNeg);
        din   = newDin;
        posEn = newPos;
        negEn = newNeg;
    endtask

    task automatic expectEvt(input int ch, input logic pol, input int atCyc);
        sbEntry_t e;
        e.evt.ch  = MAX_CH_W'(ch);
        e.evt.pol = pol;
        e.cyc     = atCyc;
        sb.push_back(e);
    endtask

    // A transfer happens at the coming posedge, so inputs sampled at negedge are final.
    always @(negedge clk) begin
        if (rst_n && evtIf.evt_valid && evtIf.evt_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_evt", 32'(evtIf.evt_valid), 0);
            end else begin
                sbEntry_t e;
                e = sb.pop_front();
                checkOutput("evt_ch", 32'(evtIf.evt_ch), 32'(e.evt.ch));
                checkOutput("evt_pol", 32'(evtIf.evt_pol), 32'(e.evt.pol));
                if (e.cyc >= 0) checkOutput("evt_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int  t0, t1;
        logic seen, stable;
        clk = 0; cyc = 0; rst_n = 0; ovfClr = 0;
        checkCount = 0; passCount = 0;
        evtIf.evt_ready = 0;
        applyStimulus(4'h0, 4'h0, 4'h0);

        step(2);
        checkOutput("rst_valid", 32'(evtIf.evt_valid), 0);
        checkOutput("rst_ch", 32'(evtIf.evt_ch), 0);
        checkOutput("rst_pol", 32'(evtIf.evt_pol), 0);
        checkOutput("rst_ovf", 32'(ovf), 0);
        rst_n = 1;
        step(1);

        // Single rising edge, then an ignored falling edge
        applyStimulus(4'h0, 4'hF, 4'h0);
        evtIf.evt_ready = 1;
        step(1);
        t0 = cyc;
        din[2] = 1;
        expectEvt(2, 1, t0 + 4);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (evtIf.evt_valid) seen = 1;
        end
        checkOutput("rise_not_early", 32'(seen), 0);
        step(1);
        checkOutput("rise_valid", 32'(evtIf.evt_valid), 1);
        checkOutput("rise_ch", 32'(evtIf.evt_ch), 2);
        step(1);
        checkOutput("rise_one_clk", 32'(evtIf.evt_valid), 0);
        din[2] = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (evtIf.evt_valid) seen = 1;
        end
        checkOutput("fall_ignored", 32'(seen), 0);

        // Round robin from the reset pointer, then wrap
        rst_n = 0;
        step(2);
        rst_n = 1;
        step(1);
        t0 = cyc;
        din = 4'b1011;
        expectEvt(0, 1, t0 + 4);
        expectEvt(1, 1, t0 + 5);
        expectEvt(3, 1, t0 + 6);
        step(8);
        din = 4'b0000;
        step(4);
        t0 = cyc;
        din = 4'b0011;
        expectEvt(0, 1, t0 + 4);
        expectEvt(1, 1, t0 + 5);
        step(8);
        checkOutput("rr_drained", sb.size(), 0);

        // Backpressure holds the output stable
        din = 4'b0000;
        step(4);
        evtIf.evt_ready = 0;
        din = 4'b0010;
        expectEvt(1, 1, -1);
        step(1);
        din = 4'b0110;
        expectEvt(2, 1, -1);
        step(4);
        checkOutput("bp_valid", 32'(evtIf.evt_valid), 1);
        checkOutput("bp_ch", 32'(evtIf.evt_ch), 1);
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (!(evtIf.evt_valid && evtIf.evt_ch == 2'd1 && evtIf.evt_pol)) stable = 0;
        end
        checkOutput("bp_stable", 32'(stable), 1);
        evtIf.evt_ready = 1;
        step(1);
        checkOutput("bp_next_valid", 32'(evtIf.evt_valid), 1);
        checkOutput("bp_next_ch", 32'(evtIf.evt_ch), 2);
        step(2);
        checkOutput("bp_idle", 32'(evtIf.evt_valid), 0);

        // Overflow keeps the oldest event; clear loses to a simultaneous overflow
        din = 4'b0000;
        step(4);
        evtIf.evt_ready = 0;
        applyStimulus(4'b1000, 4'hF, 4'b0001);
        expectEvt(3, 1, -1);
        step(5);
        din = 4'b1001;
        expectEvt(0, 1, -1);
        step(5);
        din = 4'b1000;
        step(2);
        checkOutput("ovf_not_early", 32'(ovf), 0);
        step(1);
        checkOutput("ovf_set", 32'(ovf), 32'h1);
        din = 4'b1001;
        step(2);
        ovfClr = 1;
        step(1);
        ovfClr = 0;
        checkOutput("ovf_clr_vs_set", 32'(ovf), 32'h1);
        step(1);
        ovfClr = 1;
        step(1);
        ovfClr = 0;
        checkOutput("ovf_clr", 32'(ovf), 0);
        checkOutput("ovf_hold_ch", 32'(evtIf.evt_ch), 3);
        evtIf.evt_ready = 1;
        step(6);
        checkOutput("ovf_drained", sb.size(), 0);

        // Both-edge mode on channel 3
        applyStimulus(4'b1001, 4'hF, 4'h0);
        din = 4'b0000;
        step(5);
        negEn = 4'b1000;
        t0 = cyc;
        din = 4'b1000;
        expectEvt(3, 1, t0 + 4);
        step(5);
        t1 = cyc;
        din = 4'b0000;
        expectEvt(3, 0, t1 + 4);
        step(8);
        checkOutput("both_drained", sb.size(), 0);

        // Asynchronous reset mid-flight, then a pin held high across release
        negEn = 4'h0;
        evtIf.evt_ready = 0;
        din = 4'b1110;
        step(5);
        checkOutput("mid_valid", 32'(evtIf.evt_valid), 1);
        checkOutput("mid_ch", 32'(evtIf.evt_ch), 1);
        #2;
        rst_n = 0;
        #1;
        checkOutput("async_valid", 32'(evtIf.evt_valid), 0);
        checkOutput("async_ch", 32'(evtIf.evt_ch), 0);
        checkOutput("async_pol", 32'(evtIf.evt_pol), 0);
        din = 4'b0010;
        evtIf.evt_ready = 1;
        step(2);
        rst_n = 1;
        t0 = cyc;
        expectEvt(1, 1, t0 + 4);
        step(8);
        checkOutput("post_rst_drained", sb.size(), 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
